// File: rtl/regfile_game_io_if.sv
// Bus between the CPU datapath / VGA renderer and the game I/O register file.
interface regfile_game_io_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 5,
  parameter int NUM_SPRITES = 8
);
  logic                              ctrl_writeEn;
  logic [ADDR_WIDTH-1:0]             ctrl_writeReg;
  logic [DATA_WIDTH-1:0]             data_writeReg;
  logic [ADDR_WIDTH-1:0]             ctrl_readRegA;
  logic [ADDR_WIDTH-1:0]             ctrl_readRegB;
  logic [DATA_WIDTH-1:0]             data_readRegA;
  logic [DATA_WIDTH-1:0]             data_readRegB;
  logic                              screenEnd;
  logic [NUM_SPRITES*DATA_WIDTH-1:0] sprite_x;
  logic [NUM_SPRITES*DATA_WIDTH-1:0] sprite_y;
  logic [DATA_WIDTH-1:0]             rand_out;
  logic                              screen_pulse;

  modport master (
    output ctrl_writeEn, ctrl_writeReg, data_writeReg, ctrl_readRegA, ctrl_readRegB, screenEnd,
    input  data_readRegA, data_readRegB, sprite_x, sprite_y, rand_out, screen_pulse
  );

  modport slave (
    input  ctrl_writeEn, ctrl_writeReg, data_writeReg, ctrl_readRegA, ctrl_readRegB, screenEnd,
    output data_readRegA, data_readRegB, sprite_x, sprite_y, rand_out, screen_pulse
  );
endinterface

// File: rtl/regfile_game_io.sv
// Register file with hardware-managed LFSR and frame-status registers and
// exported sprite X/Y windows for the renderer.
module regfile_game_io #(
  parameter int          DATA_WIDTH  = 32,
  parameter int          ADDR_WIDTH  = 5,
  parameter int          NUM_SPRITES = 8,
  parameter int          X_BASE      = 1,
  parameter int          Y_BASE      = 9,
  parameter int          RAND_REG    = 29,
  parameter int          SCREEN_REG  = 30,
  parameter bit          BYPASS      = 1'b1,
  parameter logic [31:0] LFSR_SEED   = 32'h0000_0001
) (
  input logic               clock,
  input logic               ctrl_reset,
  regfile_game_io_if.slave  bus
);

  localparam int NREGS = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] RAND_IDX   = ADDR_WIDTH'(RAND_REG);
  localparam logic [ADDR_WIDTH-1:0] SCREEN_IDX = ADDR_WIDTH'(SCREEN_REG);
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  function automatic bit in_window(input int idx, input int base);
    return (idx >= base) && (idx < base + NUM_SPRITES);
  endfunction

  localparam bit CFG_BAD =
      (DATA_WIDTH < 32) || (LFSR_SEED == 32'd0) ||
      (X_BASE < 1) || (Y_BASE < 1) ||
      (X_BASE + NUM_SPRITES > NREGS) || (Y_BASE + NUM_SPRITES > NREGS) ||
      ((X_BASE < Y_BASE + NUM_SPRITES) && (Y_BASE < X_BASE + NUM_SPRITES)) ||
      (RAND_REG < 1) || (RAND_REG >= NREGS) || (SCREEN_REG < 1) || (SCREEN_REG >= NREGS) ||
      (RAND_REG == SCREEN_REG) ||
      in_window(RAND_REG, X_BASE) || in_window(RAND_REG, Y_BASE) ||
      in_window(SCREEN_REG, X_BASE) || in_window(SCREEN_REG, Y_BASE);

  if (CFG_BAD) begin : g_cfg_error
    $error("regfile_game_io: illegal register map or width/seed parameters");
  end

  logic [DATA_WIDTH-1:0] regs [NREGS];
  logic [31:0]           lfsr;
  logic                  sticky;
  logic [15:0]           frame_cnt;
  logic                  screen_end_q;
  logic                  screen_pulse_r;
  logic                  rise;
  logic                  wr_general;
  logic                  wr_rand;
  logic                  wr_screen;

  assign rise       = bus.screenEnd & ~screen_end_q;
  assign wr_rand    = bus.ctrl_writeEn && (bus.ctrl_writeReg == RAND_IDX);
  assign wr_screen  = bus.ctrl_writeEn && (bus.ctrl_writeReg == SCREEN_IDX);
  assign wr_general = bus.ctrl_writeEn && (bus.ctrl_writeReg != '0) && !wr_rand && !wr_screen;

  always_ff @(posedge clock) begin
    if (!ctrl_reset) begin
      regs           <= '{default: '0};
      lfsr           <= LFSR_SEED;
      sticky         <= 1'b0;
      frame_cnt      <= 16'd0;
      screen_end_q   <= 1'b0;
      screen_pulse_r <= 1'b0;
    end else begin
      if (wr_general)
        regs[bus.ctrl_writeReg] <= bus.data_writeReg;

      // A zero load would lock the LFSR, so it reseeds instead.
      if (wr_rand)
        lfsr <= (bus.data_writeReg[31:0] == 32'd0) ? LFSR_SEED : bus.data_writeReg[31:0];
      else if (lfsr[0])
        lfsr <= (lfsr >> 1) ^ LFSR_TAPS;
      else
        lfsr <= lfsr >> 1;

      screen_end_q   <= bus.screenEnd;
      screen_pulse_r <= rise;
      // A frame edge beats a software clear landing in the same cycle.
      if (rise) begin
        sticky    <= 1'b1;
        frame_cnt <= frame_cnt + 16'd1;
      end else if (wr_screen) begin
        sticky    <= 1'b0;
      end
    end
  end

  function automatic logic [DATA_WIDTH-1:0] read_port(input logic [ADDR_WIDTH-1:0] addr);
    logic [DATA_WIDTH-1:0] r;
    if (addr == '0)
      r = '0;
    else if (addr == RAND_IDX)
      r = DATA_WIDTH'(lfsr);
    else if (addr == SCREEN_IDX)
      r = DATA_WIDTH'({frame_cnt, 15'd0, sticky});
    else if (BYPASS && bus.ctrl_writeEn && (addr == bus.ctrl_writeReg))
      r = bus.data_writeReg;
    else
      r = regs[addr];
    return r;
  endfunction

  always_comb begin
    bus.data_readRegA = read_port(bus.ctrl_readRegA);
    bus.data_readRegB = read_port(bus.ctrl_readRegB);
  end

  always_comb begin
    bus.sprite_x = '0;
    bus.sprite_y = '0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      bus.sprite_x[i*DATA_WIDTH +: DATA_WIDTH] = regs[ADDR_WIDTH'(X_BASE + i)];
      bus.sprite_y[i*DATA_WIDTH +: DATA_WIDTH] = regs[ADDR_WIDTH'(Y_BASE + i)];
    end
  end

  assign bus.rand_out     = DATA_WIDTH'(lfsr);
  assign bus.screen_pulse = screen_pulse_r;

endmodule

// File: doc/regfile_game_io.md
Name: regfile_game_io

Overview:
Parametrised successor to the processor register file. It adds hardware-managed game I/O registers: a free-running LFSR random register and a frame-status register fed by the VGA screen-end strobe. It also exports configurable sprite X/Y register windows. It sits between the CPU datapath and the VGA/sprite renderer.

Parameters:
DATA_WIDTH, 32, register width; must be >= 32.
ADDR_WIDTH, 5, register address width; register count is 2**ADDR_WIDTH.
NUM_SPRITES, 8, number of exported X and Y register pairs.
X_BASE, 1, first sprite-X register index.
Y_BASE, 9, first sprite-Y register index.
RAND_REG, 29, index of the LFSR random register.
SCREEN_REG, 30, index of the frame-status register.
BYPASS, 1, 1 = same-cycle write-to-read forwarding on general registers.
LFSR_SEED, 32'h0000_0001, LFSR reset/reseed value; must be nonzero.

Ports:
clock  in  1  single clock; all state updates on posedge
ctrl_reset  in  1  synchronous, active-low reset
ctrl_writeEn  in  1  write enable
ctrl_writeReg  in  ADDR_WIDTH  write address
data_writeReg  in  DATA_WIDTH  write data
ctrl_readRegA  in  ADDR_WIDTH  read address A
ctrl_readRegB  in  ADDR_WIDTH  read address B
data_readRegA  out  DATA_WIDTH  read data A, combinational
data_readRegB  out  DATA_WIDTH  read data B, combinational
screenEnd  in  1  level from VGA, already synchronous to clock; high = end of frame
sprite_x  out  NUM_SPRITES*DATA_WIDTH  flat; slice i = reg[X_BASE+i]
sprite_y  out  NUM_SPRITES*DATA_WIDTH  flat; slice i = reg[Y_BASE+i]
rand_out  out  DATA_WIDTH  current LFSR value, zero-extended
screen_pulse  out  1  one-cycle pulse per screenEnd rising edge

Behaviour:
- Reset
  - Sampled at posedge with ctrl_reset==0.
  - Clears all general registers to 0. Sets LFSR=LFSR_SEED. Clears sticky flag, frame counter, screenEnd_q and screen_pulse to 0.
  - Reset dominates any write or edge in the same cycle. Reset mid-frame drops any pending pulse.
- Register 0: always reads 0; writes are ignored.
- General registers (every index except 0, RAND_REG, SCREEN_REG)
  - Written at posedge when ctrl_writeEn=1.
- Reads
  - Combinational from storage.
  - BYPASS=1: if ctrl_writeEn=1 and the read address equals ctrl_writeReg and is a general register, data_writeReg is returned in the same cycle.
  - No bypass for index 0, RAND_REG or SCREEN_REG.
- RAND_REG (32-bit Galois LFSR)
  - Every non-reset cycle: if lfsr[0]=1, lfsr <= (lfsr>>1) ^ 32'h8020_0003; else lfsr <= lfsr>>1.
  - A write to RAND_REG loads data_writeReg[31:0] instead of stepping. A zero write loads LFSR_SEED, so the LFSR never locks up.
  - Reads and rand_out return the pre-edge value, zero-extended to DATA_WIDTH.
- SCREEN_REG
  - screenEnd_q <= screenEnd every cycle. Rising edge = screenEnd & ~screenEnd_q.
  - On a rising edge: sticky <= 1, frame_cnt <= frame_cnt+1 (16-bit, wraps 0xFFFF->0), screen_pulse <= 1. Otherwise screen_pulse <= 0.
  - Pulse appears one cycle after the edge is sampled. A held-high screenEnd gives exactly one pulse.
  - Read value: bit0 = sticky, bits[31:16] = frame_cnt, all other bits 0.
  - Any write to SCREEN_REG clears sticky; frame_cnt is unaffected.
  - Rising edge and clearing write in the same cycle: set wins, sticky=1.
- Sprite outputs: driven directly from storage. They reflect a write from the next posedge; there is no bypass on these outputs.
- Elaboration check: the X and Y windows must not overlap each other, must not include 0, RAND_REG or SCREEN_REG, and must fit within 2**ADDR_WIDTH. Violation triggers $error.
- Two reads of the same address return identical data.

Test Plan:
- Reset, then read all 32 addresses -> general registers read 0; reg29 = 0x00000001; reg30 = 0; screen_pulse = 0.
- Write 1234 to reg7, read A=7 in the same cycle with BYPASS=1 -> 1234. Next cycle sprite_x slice 6 = 1234. Write 55 to reg0 -> reads 0.
- After reset with seed 1 -> reg29 reads 0x00000001, then 0x80200003, then 0xC0300002 on successive cycles. Write 0 to reg29 -> next read 0x00000001.
- Drive screenEnd 0,1,1,1,0,1 on consecutive cycles -> exactly two screen_pulse cycles, each one cycle after its edge. reg30 reads 0x00020001.
- Write reg30 in the same cycle as a screenEnd rising edge -> sticky stays 1. Write again with no edge -> bit0 = 0, frame_cnt unchanged.
- Force frame_cnt to 0xFFFF via 65535 edges, then one more edge -> reg30[31:16] = 0. Assert reset mid-write to reg3 -> reg3 = 0 and LFSR = seed.
